// File: rtl/muldiv_sequencer.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the E stage.
// Results are computed at issue, held for a fixed latency, then committed to HI/LO.
module muldiv_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    input  logic        md_use_d,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        pend_hi_q, pend_hi_d;
    logic [31:0]        pend_lo_q, pend_lo_d;
    logic               pend_wr_q, pend_wr_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;

    logic               issue;
    logic [63:0]        prod_s, prod_u;
    logic [31:0]        divisor;
    logic [31:0]        quot_s, rem_s, quot_u, rem_u;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'b0, a} * {32'b0, b};

    // A zero divisor is replaced so the divider never sees it; that result is never committed.
    assign divisor = (b == 32'd0) ? 32'd1 : b;

    always_comb begin
        quot_s = 32'd0;
        rem_s  = 32'd0;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            quot_s = 32'h8000_0000;
            rem_s  = 32'd0;
        end else begin
            quot_s = $signed(a) / $signed(divisor);
            rem_s  = $signed(a) % $signed(divisor);
        end
    end

    assign quot_u = a / divisor;
    assign rem_u  = a % divisor;

    assign issue = start & ~cancel & (state_q == IDLE);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            IDLE: begin
                if (issue) begin
                    case (op)
                        3'b000: begin
                            pend_hi_d = prod_s[63:32];
                            pend_lo_d = prod_s[31:0];
                            pend_wr_d = 1'b1;
                            cnt_d     = CNT_W'(MULT_CYCLES);
                            state_d   = BUSY;
                        end
                        3'b001: begin
                            pend_hi_d = prod_u[63:32];
                            pend_lo_d = prod_u[31:0];
                            pend_wr_d = 1'b1;
                            cnt_d     = CNT_W'(MULT_CYCLES);
                            state_d   = BUSY;
                        end
                        3'b010: begin
                            pend_hi_d = rem_s;
                            pend_lo_d = quot_s;
                            pend_wr_d = (b != 32'd0);
                            cnt_d     = CNT_W'(DIV_CYCLES);
                            state_d   = BUSY;
                        end
                        3'b011: begin
                            pend_hi_d = rem_u;
                            pend_lo_d = quot_u;
                            pend_wr_d = (b != 32'd0);
                            cnt_d     = CNT_W'(DIV_CYCLES);
                            state_d   = BUSY;
                        end
                        3'b100:  hi_d = a;
                        3'b101:  lo_d = a;
                        default: ;
                    endcase
                end
            end
            BUSY: begin
                if (cnt_q == CNT_W'(1)) begin
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_wr_q <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy  = (state_q == BUSY);
    assign stall = md_use_d & (busy | (start & ~cancel & ~op[2]));
    assign hi    = hi_q;
    assign lo    = lo_q;
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle multiply/divide unit with HI/LO registers, used by the Execute stage of the pipelined MIPS core.
- Accepts mult/multu/div/divu/mthi/mtlo from E stage and holds the result internally for a fixed latency before committing it to HI/LO.
- Drives busy, plus a stall request to the hazard logic, so that no following HI/LO-using instruction issues early.
- Lets the exception logic cancel an issue.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1).
- DIV_CYCLES, 10, busy cycles for div/divu (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  E-stage instruction is mult/multu/div/divu/mthi/mtlo.
- op  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; 110/111 reserved.
- a  input  32  rs operand, forwarded value.
- b  input  32  rt operand, forwarded value.
- cancel  input  1  exception/flush in the issuing cycle; masks start.
- md_use_d  input  1  D-stage instruction is any mult/div/mfhi/mflo/mthi/mtlo.
- busy  output  1  operation in progress.
- stall  output  1  freeze F/D, bubble into E.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset (asynchronous, any state): hi=0, lo=0, busy=0, counter=0, pending results=0, state IDLE. Applies immediately, including mid-operation; the pending result is discarded.
- Accepted issue: start & !cancel & state==IDLE. start with cancel=1 has no effect of any kind.
- States:
  - IDLE: busy=0.
  - BUSY: busy=1.
- IDLE, accepted issue, op mult/multu/div/divu at edge T:
  - Compute the result combinationally from a, b and latch it into pending_hi/pending_lo.
  - Load counter with MULT_CYCLES or DIV_CYCLES; go to BUSY.
- BUSY:
  - Counter decrements each edge.
  - At the edge where counter==1: hi<=pending_hi, lo<=pending_lo, go to IDLE.
  - busy is high for exactly N cycles after edge T. New hi/lo are visible in the same cycle busy falls.
- mthi/mtlo, accepted in IDLE: hi<=a or lo<=a at the same edge. No busy; the other register is unchanged.
- Reserved op: no effect.
- start while BUSY: ignored. Hazard logic guarantees this cannot occur; the bench checks it via assertion.
- Arithmetic:
  - mult: signed 32x32->64.
  - multu: unsigned 32x32->64.
  - In both cases hi = product[63:32], lo = product[31:0].
  - div/divu: lo = quotient, hi = remainder.
  - Signed division truncates toward zero; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF (signed): lo=0x80000000, hi=0.
- Divide by zero (b==0, div or divu): full DIV_CYCLES busy; hi/lo keep their prior values at commit.
- stall = md_use_d & (busy | (start & !cancel & op[2]==0)). This is combinational and stays low when md_use_d=0.
- cancel while BUSY does not abort. An operation already past E always commits.
- No other outputs change except at the edges described above.

Test Plan:
- Signed multiply: reset, then start op=000, a=0xFFFFFFFD, b=5. Required: busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- Unsigned multiply: op=001, a=0xFFFFFFFF, b=2. Required: after 5 cycles hi=0x00000001, lo=0xFFFFFFFE.
- Signed divide: op=010, a=0xFFFFFFF9 (-7), b=2. Required: busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Overflow case: a=0x80000000, b=0xFFFFFFFF. Required: lo=0x80000000, hi=0.
- Divide by zero: preload hi=0x11, lo=0x22 via mthi/mtlo (each takes effect the next cycle, busy stays 0), then div by b=0. Required: busy 10 cycles, hi=0x11, lo=0x22 unchanged.
- Cancel and stall:
  - start op=000 with cancel=1 -> busy stays 0, hi/lo unchanged.
  - start op=010 with md_use_d=1 -> stall=1 in the issue cycle and through all 10 busy cycles, 0 after.
  - md_use_d=0 -> stall=0 throughout.
- Reset mid-operation: assert reset asynchronously (between edges) at busy cycle 3 of a mult. Required: busy=0, hi=0, lo=0 immediately; no commit after reset is released.
